// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, ALU operation codes and control word layout.
package pipe_pkg;

  localparam int CW = 12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;
  localparam logic [5:0] ALU_AND = 6'h24;
  localparam logic [5:0] ALU_OR  = 6'h25;

  localparam int CB_BRANCH     = 11;
  localparam int CB_MEM_WRITE  = 10;
  localparam int CB_MEM_TO_REG = 9;
  localparam int CB_REG_DST    = 8;
  localparam int CB_REG_WRITE  = 7;
  localparam int CB_ALU_SRC    = 6;

  // Bit order matches CB_* indices: branch is the MSB, alu_op the low six bits.
  typedef struct packed {
    logic       branch;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic [5:0] alu_op;
  } ctrl_word_t;

endpackage

// File: rtl/register_bank_bp.sv
// Register bank with hard-wired zero register and write-through read bypass.
module register_bank_bp #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2
);

  logic [DW-1:0] mem [NREG];

  // Write port: register 0 is never written; reset clears the whole bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // Read ports: a same-cycle write to the addressed register is forwarded.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (we && (wa == ra1)) ? wd : mem[ra1];
    if (ra2 != '0) rd2 = (we && (wa == ra2)) ? wd : mem[ra2];
  end

endmodule

// File: rtl/decode_stage_hz.sv
// Instruction decode stage: operand read, immediate extension, control decode,
// load-use hazard detection and the registered ID/EX boundary.
module decode_stage_hz
  import pipe_pkg::*;
#(
  parameter int DW    = 32,
  parameter int NREG  = 32,
  parameter int CW    = 12,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [31:0]              instruccion,
  input  logic                     reg_write_in,
  input  logic [$clog2(NREG)-1:0]  WR,
  input  logic [DW-1:0]            WD,
  output logic                     ex_valid,
  output logic [DW-1:0]            data1,
  output logic [DW-1:0]            data2,
  output logic [DW-1:0]            ext_sig,
  output logic [$clog2(NREG)-1:0]  rt_out,
  output logic [$clog2(NREG)-1:0]  rd_out,
  output logic [CW-1:0]            palabra_salida,
  output logic                     illegal,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_count
);

  localparam int AW = $clog2(NREG);

  function automatic logic [DW-1:0] extend_imm(input logic [15:0] imm, input logic zero_ext);
    logic signed [15:0] simm;
    logic signed [DW-1:0] sext;
    simm = imm;
    sext = simm;
    return zero_ext ? {{(DW-16){1'b0}}, imm} : sext;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // ---- stage p0: decode of the IF/ID word ----
  logic [5:0]    opcode_p0;
  logic [AW-1:0] rs_p0, rt_p0, rd_p0;
  logic [DW-1:0] rd1_p0, rd2_p0, ext_p0;
  ctrl_word_t    ctrl_p0;
  logic          unknown_p0;
  logic          uses_rt_p0;

  assign opcode_p0 = instruccion[31:26];
  assign rs_p0     = instruccion[21 +: AW];
  assign rt_p0     = instruccion[16 +: AW];
  assign rd_p0     = instruccion[11 +: AW];
  assign ext_p0    = extend_imm(instruccion[15:0], (opcode_p0 == OP_ANDI) || (opcode_p0 == OP_ORI));
  assign uses_rt_p0 = (opcode_p0 == OP_RTYPE) || (opcode_p0 == OP_SW) || (opcode_p0 == OP_BEQ);

  register_bank_bp #(.DW(DW), .NREG(NREG), .AW(AW)) u_bank (
    .clk (clk),
    .rst (rst),
    .we  (reg_write_in),
    .wa  (WR),
    .wd  (WD),
    .ra1 (rs_p0),
    .ra2 (rt_p0),
    .rd1 (rd1_p0),
    .rd2 (rd2_p0)
  );

  // Opcode to control word; unknown opcodes yield an all-zero word.
  always_comb begin
    ctrl_p0    = '0;
    unknown_p0 = 1'b0;
    case (opcode_p0)
      OP_RTYPE: begin
        ctrl_p0.reg_dst   = 1'b1;
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.alu_op    = instruccion[5:0];
      end
      OP_LW: begin
        ctrl_p0.mem_to_reg = 1'b1;
        ctrl_p0.reg_write  = 1'b1;
        ctrl_p0.alu_src    = 1'b1;
        ctrl_p0.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl_p0.mem_write = 1'b1;
        ctrl_p0.alu_src   = 1'b1;
        ctrl_p0.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_p0.branch = 1'b1;
        ctrl_p0.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.alu_src   = 1'b1;
        ctrl_p0.alu_op    = ALU_ADD;
      end
      OP_ANDI: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.alu_src   = 1'b1;
        ctrl_p0.alu_op    = ALU_AND;
      end
      OP_ORI: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.alu_src   = 1'b1;
        ctrl_p0.alu_op    = ALU_OR;
      end
      default: unknown_p0 = 1'b1;
    endcase
  end

  // ---- stage p1: ID/EX register ----
  logic          vld_p1;
  logic [DW-1:0] data1_p1, data2_p1, ext_p1;
  logic [AW-1:0] rt_p1, rd_p1;
  ctrl_word_t    word_p1;
  logic          illegal_p1;
  logic [CNT_W-1:0] cnt_p1;

  // Load-use: the load in ID/EX targets a register this instruction reads.
  // rt is only a source for R-type, SW and BEQ; elsewhere it is a destination.
  assign stall = id_valid && vld_p1 && word_p1.mem_to_reg && (rt_p1 != '0) &&
                 ((rt_p1 == rs_p0) || ((rt_p1 == rt_p0) && uses_rt_p0));

  // ID/EX update: flush and stall both insert a bubble, leaving data fields held.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      data1_p1   <= '0;
      data2_p1   <= '0;
      ext_p1     <= '0;
      rt_p1      <= '0;
      rd_p1      <= '0;
      word_p1    <= '0;
      illegal_p1 <= 1'b0;
    end else if (flush || stall) begin
      vld_p1     <= 1'b0;
      word_p1    <= '0;
      illegal_p1 <= 1'b0;
    end else if (ena) begin
      vld_p1     <= id_valid;
      data1_p1   <= rd1_p0;
      data2_p1   <= rd2_p0;
      ext_p1     <= ext_p0;
      rt_p1      <= rt_p0;
      rd_p1      <= rd_p0;
      word_p1    <= id_valid ? ctrl_p0 : '0;
      illegal_p1 <= id_valid && unknown_p0;
    end
  end

  // Stall cycles are counted only when the stage is enabled and not being flushed.
  always_ff @(posedge clk) begin
    if (rst) cnt_p1 <= '0;
    else if (stall && ena && !flush) cnt_p1 <= sat_inc(cnt_p1);
  end

  assign ex_valid       = vld_p1;
  assign data1          = data1_p1;
  assign data2          = data2_p1;
  assign ext_sig        = ext_p1;
  assign rt_out         = rt_p1;
  assign rd_out         = rd_p1;
  assign palabra_salida = word_p1;
  assign illegal        = illegal_p1;
  assign stall_count    = cnt_p1;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz with an expected-result queue per clock edge.
module tb_decode_stage_hz;

  localparam int CNT_W = 6;

  typedef struct packed {
    logic        ex_valid;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] ext;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [11:0] word;
    logic        illegal;
    logic [5:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, ena, flush, id_valid, reg_write_in;
  logic [31:0] instruccion;
  logic [4:0]  WR;
  logic [31:0] WD;
  logic        ex_valid, illegal, stall;
  logic [31:0] data1, data2, ext_sig;
  logic [4:0]  rt_out, rd_out;
  logic [11:0] palabra_salida;
  logic [5:0]  stall_count;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t last;

  always #5 clk = ~clk;

  decode_stage_hz #(.DW(32), .NREG(32), .CW(12), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .ena            (ena),
    .flush          (flush),
    .id_valid       (id_valid),
    .instruccion    (instruccion),
    .reg_write_in   (reg_write_in),
    .WR             (WR),
    .WD             (WD),
    .ex_valid       (ex_valid),
    .data1          (data1),
    .data2          (data2),
    .ext_sig        (ext_sig),
    .rt_out         (rt_out),
    .rd_out         (rd_out),
    .palabra_salida (palabra_salida),
    .illegal        (illegal),
    .stall          (stall),
    .stall_count    (stall_count)
  );

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic exp_t mk(input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] x, input logic [4:0] t, input logic [4:0] d,
                              input logic [11:0] w, input logic il, input logic [5:0] c);
    exp_t e;
    e.ex_valid = v; e.d1 = a; e.d2 = b; e.ext = x; e.rt = t; e.rd = d;
    e.word = w; e.illegal = il; e.cnt = c;
    return e;
  endfunction

  function automatic exp_t bub(input exp_t prev, input logic [5:0] c);
    exp_t e;
    e = prev;
    e.ex_valid = 1'b0;
    e.word     = '0;
    e.illegal  = 1'b0;
    e.cnt      = c;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    assert (act === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, expv);
    end
  endtask

  // Inputs are already set (at the falling edge); check stall, queue the expected
  // ID/EX state, clock once and compare #1 after the rising edge.
  task automatic cycle(input exp_t e, input logic exp_stall, input logic do_stall_chk);
    exp_t got;
    #1;
    if (do_stall_chk) chk("stall", stall, exp_stall);
    exp_q.push_back(e);
    last = e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 1, 0);
    end else begin
      got = exp_q.pop_front();
      chk("ex_valid", ex_valid, got.ex_valid);
      chk("data1", data1, got.d1);
      chk("data2", data2, got.d2);
      chk("ext_sig", ext_sig, got.ext);
      chk("rt_out", rt_out, got.rt);
      chk("rd_out", rd_out, got.rd);
      chk("palabra", palabra_salida, got.word);
      chk("illegal", illegal, got.illegal);
      chk("stall_count", stall_count, got.cnt);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t lw2;
    exp_t addi1;
    int   c;

    rst = 1'b1; ena = 1'b1; flush = 1'b0; id_valid = 1'b0; instruccion = '0;
    reg_write_in = 1'b0; WR = '0; WD = '0;
    @(negedge clk);

    // Reset held two cycles: everything zero.
    cycle('0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b1);
    rst = 1'b0;

    // ADDI r1,r0,-3: sign-extended immediate, rw+asrc, ALU add.
    id_valid = 1'b1;
    instruccion = itype(6'h08, 5'd0, 5'd1, 16'hFFFD);
    addi1 = mk(1, 0, 0, 32'hFFFF_FFFD, 5'd1, 5'd31, 12'h0E0, 0, 0);
    cycle(addi1, 1'b0, 1'b1);

    // Write-through: r5 written while being read.
    instruccion = rtype(5'd5, 5'd0, 5'd6, 6'h20);
    reg_write_in = 1'b1; WR = 5'd5; WD = 32'h0000_1234;
    cycle(mk(1, 32'h1234, 0, 32'h3020, 5'd0, 5'd6, 12'h1A0, 0, 0), 1'b0, 1'b1);
    // r5 now stored; r4 written this cycle for later use.
    instruccion = rtype(5'd5, 5'd5, 5'd7, 6'h22);
    WR = 5'd4; WD = 32'h0000_0055;
    cycle(mk(1, 32'h1234, 32'h1234, 32'h3822, 5'd5, 5'd7, 12'h1A2, 0, 0), 1'b0, 1'b1);
    reg_write_in = 1'b0;

    // Load-use on rs: LW r2 then ADD r3,r2,r4.
    instruccion = itype(6'h23, 5'd1, 5'd2, 16'h0000);
    lw2 = mk(1, 0, 0, 0, 5'd2, 5'd0, 12'h2E0, 0, 0);
    cycle(lw2, 1'b0, 1'b1);
    instruccion = rtype(5'd2, 5'd4, 5'd3, 6'h20);
    cycle(bub(last, 1), 1'b1, 1'b1);
    cycle(mk(1, 0, 32'h55, 32'h1820, 5'd4, 5'd3, 12'h1A0, 0, 1), 1'b0, 1'b1);
    // LW to r0 never stalls.
    instruccion = itype(6'h23, 5'd1, 5'd0, 16'h0000);
    cycle(mk(1, 0, 0, 0, 5'd0, 5'd0, 12'h2E0, 0, 1), 1'b0, 1'b1);
    instruccion = rtype(5'd0, 5'd4, 5'd3, 6'h20);
    cycle(mk(1, 0, 32'h55, 32'h1820, 5'd4, 5'd3, 12'h1A0, 0, 1), 1'b0, 1'b1);

    // Stall with flush in the same cycle: bubble, counter unchanged.
    lw2.cnt = 1;
    instruccion = itype(6'h23, 5'd1, 5'd2, 16'h0000);
    cycle(lw2, 1'b0, 1'b1);
    instruccion = rtype(5'd2, 5'd4, 5'd3, 6'h20);
    flush = 1'b1;
    cycle(bub(last, 1), 1'b1, 1'b1);
    flush = 1'b0;

    // LW r2 then ORI writing r2: rt is a destination, no stall; zero-extended imm.
    instruccion = itype(6'h23, 5'd1, 5'd2, 16'h0000);
    cycle(lw2, 1'b0, 1'b1);
    instruccion = itype(6'h0D, 5'd0, 5'd2, 16'h8000);
    cycle(mk(1, 0, 0, 32'h0000_8000, 5'd2, 5'd16, 12'h0E5, 0, 1), 1'b0, 1'b1);

    // LW r2 then SW r2: rt hazard for store.
    instruccion = itype(6'h23, 5'd1, 5'd2, 16'h0000);
    cycle(lw2, 1'b0, 1'b1);
    instruccion = itype(6'h2B, 5'd0, 5'd2, 16'h0004);
    cycle(bub(last, 2), 1'b1, 1'b1);
    cycle(mk(1, 0, 0, 32'h4, 5'd2, 5'd0, 12'h460, 0, 2), 1'b0, 1'b1);

    // Unknown opcode: word 0, illegal with valid; no illegal without valid.
    instruccion = {6'h3F, 26'h0000123};
    cycle(mk(1, 0, 0, 32'h123, 5'd0, 5'd0, 12'h000, 1, 2), 1'b0, 1'b1);
    id_valid = 1'b0;
    cycle(mk(0, 0, 0, 32'h123, 5'd0, 5'd0, 12'h000, 0, 2), 1'b0, 1'b1);
    id_valid = 1'b1;

    // ANDI zero-extends a negative-looking immediate.
    instruccion = itype(6'h0C, 5'd4, 5'd3, 16'hF0F0);
    cycle(mk(1, 32'h55, 0, 32'h0000_F0F0, 5'd3, 5'd30, 12'h0E4, 0, 2), 1'b0, 1'b1);

    // Enable low for three cycles: ID/EX holds.
    instruccion = itype(6'h08, 5'd0, 5'd1, 16'hFFFD);
    addi1.cnt = 2;
    cycle(addi1, 1'b0, 1'b1);
    ena = 1'b0;
    instruccion = rtype(5'd5, 5'd4, 5'd9, 6'h20);
    for (int i = 0; i < 3; i++) cycle(addi1, 1'b0, 1'b1);
    ena = 1'b1;
    cycle(mk(1, 32'h1234, 32'h55, 32'h4820, 5'd4, 5'd9, 12'h1A0, 0, 2), 1'b0, 1'b1);

    // BEQ decode with sign-extended offset.
    instruccion = itype(6'h04, 5'd5, 5'd4, 16'hFFFE);
    cycle(mk(1, 32'h1234, 32'h55, 32'hFFFF_FFFE, 5'd4, 5'd31, 12'h822, 0, 2), 1'b0, 1'b1);

    // Repeated LW r2,0(r2): stalls every other cycle; 2^CNT_W+5 stalls saturate the counter.
    instruccion = itype(6'h23, 5'd2, 5'd2, 16'h0000);
    c = 2;
    for (int k = 0; k < 2 * ((1 << CNT_W) + 5); k++) begin
      if (last.ex_valid && last.word == 12'h2E0 && last.rt == 5'd2) begin
        c = (c == (1 << CNT_W) - 1) ? c : c + 1;
        cycle(bub(last, 6'(c)), 1'b1, 1'b1);
      end else begin
        lw2.cnt = 6'(c);
        cycle(lw2, 1'b0, 1'b1);
      end
    end
    chk("stall_count_saturated", stall_count, 32'd63);

    // Load once more so a stall is pending, then reset over it.
    lw2.cnt = 6'd63;
    cycle(lw2, 1'b0, 1'b1);
    rst = 1'b1;
    cycle('0, 1'b0, 1'b0);
    rst = 1'b0;

    // First post-reset edge loads normally; the bank was cleared.
    instruccion = rtype(5'd5, 5'd4, 5'd3, 6'h20);
    cycle(mk(1, 0, 0, 32'h1820, 5'd4, 5'd3, 12'h1A0, 0, 0), 1'b0, 1'b1);

    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
